id_ex_pipeline_reg: RTL
=======================

Name: id_ex_pipeline_reg

Overview:
- Pipeline register between decode (control unit + register file + immediate extender) and execute (ALU, branch compare, PC target adder).
- Captures decode-stage control and datapath fields each cycle and presents them to execute one cycle later.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit, plus a valid bit marking real instructions.

Parameters:
- DATA_WIDTH, 32, width of register operands, PC, PC+4 and extended immediate
- REG_ADDR_WIDTH, 5, width of rs1/rs2/rd register indices
- ALU_CTRL_WIDTH, 4, width of ALUControl
- FUNCT3_WIDTH, 3, width of funct3 forwarded for branch-condition and load/store size selection

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous reset, active-high
- StallE  input  1  hold all E-stage outputs
- FlushE  input  1  replace the next E-stage contents with a bubble
- ValidD  input  1  decode stage holds a real instruction
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  input  1 each  control bits from control unit
- ResultSrcD  input  2  result mux select
- ALUControlD  input  ALU_CTRL_WIDTH  ALU operation
- Funct3D  input  FUNCT3_WIDTH  instruction funct3
- RD1D, RD2D  input  DATA_WIDTH each  register-file read data
- PCD, PCPlus4D, ImmExtD  input  DATA_WIDTH each  PC, PC+4, extended immediate
- Rs1D, Rs2D, RdD  input  REG_ADDR_WIDTH each  register indices (for forwarding/hazard logic)
- ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, Funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE  output  same widths as D counterparts  registered copies
- BubbleCount, StallCount  output  32 each  present only with ID_EX_PERF_CNT_EN

Behaviour:
- Reset: rst asserted -> every output is 0 immediately (asynchronous), held 0 while rst is high; first capture on first rising edge after rst deasserts.
- Latency: exactly 1 cycle; D inputs sampled at edge N appear on E outputs after edge N.
- Per rising edge, priority FlushE > StallE > normal:
  - FlushE=1: all outputs cleared to 0 (control, data, indices, ValidE). A bubble has RegWriteE=MemWriteE=JumpE=BranchE=0, so it cannot change architectural state.
  - FlushE=0, StallE=1: all outputs hold their previous value; D inputs are ignored.
  - Otherwise: every E output takes its D input; ValidE <= ValidD.
- Flush and stall asserted together: flush wins and a bubble is inserted. The hazard unit relies on this for a load-use stall coinciding with a taken branch.
- ValidD=0 with normal capture: fields are captured as presented and ValidE=0. No field gating is done by this block; the decoder supplies zeroed control for invalid instructions.
- No combinational path from any input to any output; outputs come from flops only.
- Reset asserted mid-stall or mid-flush: reset overrides immediately and all outputs go to 0.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined:
  - BubbleCount increments on every edge where FlushE=1.
  - StallCount increments on every edge where FlushE=0 and StallE=1.
  - Both are 32-bit, saturate at 0xFFFFFFFF (no wrap), and are cleared to 0 by rst.
  - Counters never affect pipeline outputs.
- Undefined: the counter ports and logic do not exist; the module is otherwise identical.

Test Plan:
- Reset: drive all D inputs to nonzero, assert rst between edges -> all E outputs 0 without waiting for clk; release -> next edge ValidE=1, RD1E=RD1D (e.g. 0xDEADBEEF).
- Pass-through: feed 4 consecutive instructions (PCD=0x0,0x4,0x8,0xC, RdD=1..4) -> PCE and RdE show each value exactly one cycle later, in order.
- Stall: capture PCD=0x10, then StallE=1 for 3 edges while PCD=0x14 -> PCE stays 0x10 for 3 cycles; after StallE=0, next edge gives PCE=0x14.
- Flush: RegWriteD=1, MemWriteD=1, BranchD=1, RdD=5, FlushE=1 -> after edge RegWriteE=MemWriteE=BranchE=0, RdE=0, ValidE=0.
- Simultaneous: StallE=1 and FlushE=1 on the same edge with valid state held -> outputs cleared (bubble), not held.
- Counters (ID_EX_PERF_CNT_EN): 5 flush edges, 7 stall-only edges, 2 edges with both asserted -> BubbleCount=7, StallCount=7. Preload near max via force -> counter sticks at 0xFFFFFFFF.

Source files
------------

// File: rtl/id_ex_pipeline_reg_if.sv
// id_ex_pipeline_reg_if
// Signal bundle between the decode stage / hazard unit and the ID/EX
// pipeline register.
//   master : decode side, drives the D fields plus StallE/FlushE and
//            observes the E fields
//   slave  : pipeline register, samples the D fields and drives the
//            E fields
interface id_ex_pipeline_reg_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int FUNCT3_WIDTH   = 3
);
    logic                      StallE;
    logic                      FlushE;

    logic                      ValidD;
    logic                      RegWriteD;
    logic                      MemWriteD;
    logic                      JumpD;
    logic                      BranchD;
    logic                      ALUSrcD;
    logic [1:0]                ResultSrcD;
    logic [ALU_CTRL_WIDTH-1:0] ALUControlD;
    logic [FUNCT3_WIDTH-1:0]   Funct3D;
    logic [DATA_WIDTH-1:0]     RD1D;
    logic [DATA_WIDTH-1:0]     RD2D;
    logic [DATA_WIDTH-1:0]     PCD;
    logic [DATA_WIDTH-1:0]     PCPlus4D;
    logic [DATA_WIDTH-1:0]     ImmExtD;
    logic [REG_ADDR_WIDTH-1:0] Rs1D;
    logic [REG_ADDR_WIDTH-1:0] Rs2D;
    logic [REG_ADDR_WIDTH-1:0] RdD;

    logic                      ValidE;
    logic                      RegWriteE;
    logic                      MemWriteE;
    logic                      JumpE;
    logic                      BranchE;
    logic                      ALUSrcE;
    logic [1:0]                ResultSrcE;
    logic [ALU_CTRL_WIDTH-1:0] ALUControlE;
    logic [FUNCT3_WIDTH-1:0]   Funct3E;
    logic [DATA_WIDTH-1:0]     RD1E;
    logic [DATA_WIDTH-1:0]     RD2E;
    logic [DATA_WIDTH-1:0]     PCE;
    logic [DATA_WIDTH-1:0]     PCPlus4E;
    logic [DATA_WIDTH-1:0]     ImmExtE;
    logic [REG_ADDR_WIDTH-1:0] Rs1E;
    logic [REG_ADDR_WIDTH-1:0] Rs2E;
    logic [REG_ADDR_WIDTH-1:0] RdE;

    modport master (
        output StallE, FlushE,
        output ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
        output ResultSrcD, ALUControlD, Funct3D,
        output RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        input  ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        input  ResultSrcE, ALUControlE, Funct3E,
        input  RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
    );

    modport slave (
        input  StallE, FlushE,
        input  ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
        input  ResultSrcD, ALUControlD, Funct3D,
        input  RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        output ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        output ResultSrcE, ALUControlE, Funct3E,
        output RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
    );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg
// Decode -> execute pipeline register. Captures every decode field on
// each rising clk edge and presents it to execute one cycle later.
// Per edge: FlushE inserts a bubble (all zero), else StallE holds, else
// the D fields (including ValidD) are captured. Outputs come straight
// from flops.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active high, clears every output
//   bus  - id_ex_pipeline_reg_if.slave (StallE/FlushE, D in, E out)
//   BubbleCount, StallCount - 32-bit saturating event counters, present
//                             only when ID_EX_PERF_CNT_EN is defined
//
// Build option: `define ID_EX_PERF_CNT_EN adds the flush/stall counters.
module id_ex_pipeline_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int FUNCT3_WIDTH   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    id_ex_pipeline_reg_if.slave  bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]          BubbleCount,
    output logic [31:0]          StallCount
`endif
);

    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic                      mem_write;
        logic                      jump;
        logic                      branch;
        logic                      alu_src;
        logic [1:0]                result_src;
        logic [ALU_CTRL_WIDTH-1:0] alu_control;
        logic [FUNCT3_WIDTH-1:0]   funct3;
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     rd2;
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [DATA_WIDTH-1:0]     imm_ext;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } stage_t;

    stage_t d_stage;
    stage_t e_q;

    always_comb begin
        d_stage             = '0;
        d_stage.valid       = bus.ValidD;
        d_stage.reg_write   = bus.RegWriteD;
        d_stage.mem_write   = bus.MemWriteD;
        d_stage.jump        = bus.JumpD;
        d_stage.branch      = bus.BranchD;
        d_stage.alu_src     = bus.ALUSrcD;
        d_stage.result_src  = bus.ResultSrcD;
        d_stage.alu_control = bus.ALUControlD;
        d_stage.funct3      = bus.Funct3D;
        d_stage.rd1         = bus.RD1D;
        d_stage.rd2         = bus.RD2D;
        d_stage.pc          = bus.PCD;
        d_stage.pc_plus4    = bus.PCPlus4D;
        d_stage.imm_ext     = bus.ImmExtD;
        d_stage.rs1         = bus.Rs1D;
        d_stage.rs2         = bus.Rs2D;
        d_stage.rd          = bus.RdD;
    end

    // Flush beats stall: a load-use stall that coincides with a taken
    // branch must still squash the instruction entering execute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
        end else if (bus.FlushE) begin
            e_q <= '0;
        end else if (!bus.StallE) begin
            e_q <= d_stage;
        end
    end

    assign bus.ValidE      = e_q.valid;
    assign bus.RegWriteE   = e_q.reg_write;
    assign bus.MemWriteE   = e_q.mem_write;
    assign bus.JumpE       = e_q.jump;
    assign bus.BranchE     = e_q.branch;
    assign bus.ALUSrcE     = e_q.alu_src;
    assign bus.ResultSrcE  = e_q.result_src;
    assign bus.ALUControlE = e_q.alu_control;
    assign bus.Funct3E     = e_q.funct3;
    assign bus.RD1E        = e_q.rd1;
    assign bus.RD2E        = e_q.rd2;
    assign bus.PCE         = e_q.pc;
    assign bus.PCPlus4E    = e_q.pc_plus4;
    assign bus.ImmExtE     = e_q.imm_ext;
    assign bus.Rs1E        = e_q.rs1;
    assign bus.Rs2E        = e_q.rs2;
    assign bus.RdE         = e_q.rd;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_count_q;
    logic [31:0] stall_count_q;

    // Saturating counters: once all-ones they stick until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count_q <= '0;
            stall_count_q  <= '0;
        end else begin
            if (bus.FlushE && (bubble_count_q != 32'hFFFF_FFFF)) begin
                bubble_count_q <= bubble_count_q + 32'd1;
            end
            if (!bus.FlushE && bus.StallE && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign BubbleCount = bubble_count_q;
    assign StallCount  = stall_count_q;
`endif

endmodule
